feistel_cipher_core: RTL and testbench

- Parametrised, iterative Feistel block cipher core; next generation of the fixed 5-round encrypt-only engine.
- Adds a generic round count, per-block encrypt/decrypt mode, indexed round-key loading and ready/valid backpressure on both streams.
- Sits between the chaos S-box generator (feeds the 256-entry S-box serially) and the image-block DMA stream.

---
 rtl/feistel_pkg.sv | 9 +
 rtl/feistel_round_f.sv | 20 ++
 rtl/feistel_cipher_core.sv | 136 +++++++++++++
 tb/tb_feistel_cipher_core.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/feistel_pkg.sv
// feistel_pkg: shared FSM states, mode encodings and key-index sizing for feistel_cipher_core.
package feistel_pkg;
  typedef enum logic [1:0] {ST_LOAD, ST_IDLE, ST_RUN, ST_DONE} state_t;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
  function automatic int key_idx_w(input int rounds);
    return (rounds > 1) ? $clog2(rounds) : 1;
  endfunction
endpackage

// File: rtl/feistel_round_f.sv
// feistel_round_f: combinational round function F(r,k) = rotl(sbox[r^k] per SBOX_WIDTH chunk, ROT).
// Ports: r (right half), k (round key), sbox (lookup table), f (result).
module feistel_round_f #(
  parameter int KEY_SIZE   = 128,
  parameter int SBOX_WIDTH = 8,
  parameter int ROT        = 3
) (
  input  logic [KEY_SIZE-1:0]   r,
  input  logic [KEY_SIZE-1:0]   k,
  input  logic [SBOX_WIDTH-1:0] sbox [2**SBOX_WIDTH],
  output logic [KEY_SIZE-1:0]   f
);
  logic [KEY_SIZE-1:0] x, s;
  assign x = r ^ k;
  for (genvar g = 0; g < KEY_SIZE / SBOX_WIDTH; g++) begin : g_sub
    assign s[g*SBOX_WIDTH +: SBOX_WIDTH] = sbox[x[g*SBOX_WIDTH +: SBOX_WIDTH]];
  end
  // A right shift by the full width yields zero, so ROT=0 degenerates cleanly to s.
  assign f = (s << ROT) | (s >> (KEY_SIZE - ROT));
endmodule

// File: rtl/feistel_cipher_core.sv
// feistel_cipher_core: iterative ROUND-round Feistel cipher, one round per cycle, ready/valid streams.
// Ports: sbox_wr_* / sbox_clear / sbox_ready load the S-box serially; key_wr_* fill the round-key file;
// s_* is the input block stream ({L,R}, mode), m_* the result stream ({R_N,L_N}); busy = RUN or DONE.
// Build option FEISTEL_DECRYPT_EN: when defined s_mode selects reversed key order, otherwise encrypt only.
module feistel_cipher_core
  import feistel_pkg::*;
#(
  parameter int ROUND      = 5,
  parameter int SBOX_WIDTH = 8,
  parameter int KEY_SIZE   = 128,
  parameter int DATA_WIDTH = 256,
  parameter int ROT        = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sbox_wr_valid,
  input  logic [SBOX_WIDTH-1:0]         sbox_wr_data,
  input  logic                          sbox_clear,
  output logic                          sbox_ready,
  input  logic                          key_wr_en,
  input  logic [key_idx_w(ROUND)-1:0]   key_wr_idx,
  input  logic [KEY_SIZE-1:0]           key_wr_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          s_mode,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          busy
);
  localparam int KW = key_idx_w(ROUND);
  localparam logic [KW-1:0] LAST = KW'(ROUND - 1);
  state_t                state_q, state_d;
  logic [SBOX_WIDTH-1:0] ptr_q, ptr_d;
  logic [KW-1:0]         cnt_q, cnt_d, key_idx;
  logic [KEY_SIZE-1:0]   l_q, l_d, r_q, r_d, f_out;
  logic [KEY_SIZE-1:0]   key_q [2**KW];
  logic [KEY_SIZE-1:0]   key_d [2**KW];
  logic [SBOX_WIDTH-1:0] sbox_q [2**SBOX_WIDTH];
  logic                  mode_q, mode_d, clr_pend_q, clr_pend_d;
  logic                  sbox_we, key_we, s_fire, m_fire;

  assign sbox_ready = state_q != ST_LOAD;
  assign s_ready    = state_q == ST_IDLE;
  assign m_valid    = state_q == ST_DONE;
  assign busy       = state_q == ST_RUN || m_valid;
  assign m_data     = {r_q, l_q};
  assign s_fire     = s_valid && s_ready;
  assign m_fire     = m_valid && m_ready;
  assign sbox_we    = state_q == ST_LOAD && sbox_wr_valid && !sbox_clear;
  assign key_we     = key_wr_en && !busy && 32'(key_wr_idx) < ROUND;

`ifdef FEISTEL_DECRYPT_EN
  assign mode_d  = s_fire ? s_mode : mode_q;
  assign key_idx = (mode_q == MODE_DEC) ? LAST - cnt_q : cnt_q;
`else
  logic unused_mode;
  assign unused_mode = s_mode ^ mode_q;
  assign mode_d      = MODE_ENC;
  assign key_idx     = cnt_q;
`endif

  // Round 0 runs the cycle after acceptance, so a key written on the accept edge is already in key_q.
  feistel_round_f #(.KEY_SIZE(KEY_SIZE), .SBOX_WIDTH(SBOX_WIDTH), .ROT(ROT)) u_f (
    .r(r_q), .k(key_q[key_idx]), .sbox(sbox_q), .f(f_out)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = sbox_we ? ptr_q + 1'b1 : ptr_q;
    cnt_d      = cnt_q;
    l_d        = l_q;
    r_d        = r_q;
    clr_pend_d = clr_pend_q || (busy && sbox_clear);
    key_d      = key_q;
    if (key_we) key_d[key_wr_idx] = key_wr_data;
    case (state_q)
      ST_LOAD: begin
        if (sbox_clear) ptr_d = '0;
        else if (sbox_we && ptr_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // An accepted block wins over a same-cycle clear; the clear is deferred until it drains.
        if (s_fire) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          {l_d, r_d} = s_data;
          clr_pend_d = sbox_clear;
        end else if (sbox_clear) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end
      ST_RUN: begin
        l_d     = r_q;
        r_d     = l_q ^ f_out;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? ST_DONE : ST_RUN;
      end
      default: begin
        if (m_fire) begin
          state_d    = (clr_pend_q || sbox_clear) ? ST_LOAD : ST_IDLE;
          clr_pend_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_LOAD;
      ptr_q      <= '0;
      cnt_q      <= '0;
      l_q        <= '0;
      r_q        <= '0;
      mode_q     <= MODE_ENC;
      clr_pend_q <= 1'b0;
      key_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      l_q        <= l_d;
      r_q        <= r_d;
      mode_q     <= mode_d;
      clr_pend_q <= clr_pend_d;
      key_q      <= key_d;
    end
  end

  // Table contents need no reset: sbox_ready stays low until every entry is rewritten.
  always_ff @(posedge clk) begin
    if (sbox_we) sbox_q[ptr_q] <= sbox_wr_data;
  end
endmodule

// File: tb/tb_feistel_cipher_core.sv
// tb_feistel_cipher_core: directed and randomized checks of feistel_cipher_core against a Feistel reference model.
module tb_feistel_cipher_core;
  logic         clk = 1'b0, reset_n = 1'b1;
  logic         sbox_wr_valid = 1'b0, sbox_clear = 1'b0, key_wr_en = 1'b0;
  logic         s_valid = 1'b0, s_mode = 1'b0, m_ready = 1'b0;
  logic [7:0]   sbox_wr_data = '0;
  logic [2:0]   key_wr_idx = '0;
  logic [127:0] key_wr_data = '0;
  logic [255:0] s_data = '0;
  logic         sbox_ready_5, s_ready_5, m_valid_5, busy_5;
  logic         sbox_ready_1, s_ready_1, m_valid_1, busy_1;
  logic [255:0] m_data_5, m_data_1;
  logic [7:0]   sb [256];
  logic [127:0] ks [5];
  int           checks = 0, errors = 0;

  always #5 clk = ~clk;

  feistel_cipher_core u5 (
    .clk(clk), .reset_n(reset_n), .sbox_wr_valid(sbox_wr_valid), .sbox_wr_data(sbox_wr_data),
    .sbox_clear(sbox_clear), .sbox_ready(sbox_ready_5), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .s_valid(s_valid), .s_ready(s_ready_5), .s_mode(s_mode), .s_data(s_data),
    .m_valid(m_valid_5), .m_ready(m_ready), .m_data(m_data_5), .busy(busy_5)
  );

  feistel_cipher_core #(.ROUND(1), .ROT(0)) u1 (
    .clk(clk), .reset_n(reset_n), .sbox_wr_valid(sbox_wr_valid), .sbox_wr_data(sbox_wr_data),
    .sbox_clear(sbox_clear), .sbox_ready(sbox_ready_1), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx[0]),
    .key_wr_data(key_wr_data), .s_valid(s_valid), .s_ready(s_ready_1), .s_mode(s_mode), .s_data(s_data),
    .m_valid(m_valid_1), .m_ready(m_ready), .m_data(m_data_1), .busy(busy_1)
  );

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] f_ref(logic [127:0] r, logic [127:0] k, int rot);
    logic [127:0] x = r ^ k;
    logic [127:0] s;
    for (int b = 0; b < 16; b++) s[b*8 +: 8] = sb[x[b*8 +: 8]];
    return (s << rot) | (s >> (128 - rot));
  endfunction

  function automatic logic [255:0] cipher(logic [255:0] d, logic dec, int rounds, int rot);
    logic [127:0] l = d[255:128];
    logic [127:0] r = d[127:0];
    logic [127:0] t;
    logic use_dec = dec;
`ifndef FEISTEL_DECRYPT_EN
    use_dec = 1'b0;
`endif
    for (int i = 0; i < rounds; i++) begin
      t = l ^ f_ref(r, ks[use_dec ? rounds - 1 - i : i], rot);
      l = r;
      r = t;
    end
    return {r, l};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_sbox(int kind);
    for (int i = 0; i < 256; i++) begin
      sb[i] = kind == 0 ? 8'(i) : kind == 1 ? 8'h00 : kind == 2 ? 8'(255 - i) : 8'($urandom);
      sbox_wr_valid = 1'b1;
      sbox_wr_data  = sb[i];
      if (i == 128) chk("s_ready mid load", 256'(s_ready_5), 256'(0));
      tick();
    end
    sbox_wr_valid = 1'b0;
  endtask

  task automatic write_key(int idx, logic [127:0] v);
    key_wr_en   = 1'b1;
    key_wr_idx  = 3'(idx);
    key_wr_data = v;
    tick();
    key_wr_en = 1'b0;
    if (idx < 5) ks[idx] = v;
  endtask

  task automatic clear_pulse();
    sbox_clear = 1'b1;
    tick();
    sbox_clear = 1'b0;
  endtask

  task automatic send(logic [255:0] d, logic md);
    int n = 0;
    while (!s_ready_5 && n < 400) begin
      tick();
      n++;
    end
    chk("s_ready before send", 256'(s_ready_5), 256'(1));
    s_valid = 1'b1;
    s_data  = d;
    s_mode  = md;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic expect_out(string tag, logic [255:0] exp, int n0);
    int n = n0;
    while (!m_valid_5 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 256'(n), 256'(5));
    chk(tag, m_data_5, exp);
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("m_valid after handshake", 256'(m_valid_5), 256'(0));
  endtask

  initial begin
    logic [255:0] d, c, p, exp;
    logic [127:0] kv;
    logic         md;
    foreach (ks[i]) ks[i] = '0;
    #2 reset_n = 1'b0;
    tick();
    chk("rst sbox_ready", 256'(sbox_ready_5), 256'(0));
    chk("rst s_ready", 256'(s_ready_5), 256'(0));
    chk("rst m_valid", 256'(m_valid_5), 256'(0));
    chk("rst m_data", m_data_5, 256'(0));
    chk("rst busy", 256'(busy_5), 256'(0));
    reset_n = 1'b1;
    tick();

    load_sbox(0);
    chk("sbox_ready after load", 256'(sbox_ready_5), 256'(1));
    write_key(0, 128'h0);
    d = {128'h1, 128'h2};
    send(d, 1'b0);
    chk("r1 valid at T", 256'(m_valid_1), 256'(0));
    tick();
    chk("r1 valid at T+1", 256'(m_valid_1), 256'(1));
    chk("r1 data", m_data_1, {128'h3, 128'h2});
    expect_out("ident r5", cipher(d, 1'b0, 5, 3), 1);
    handshake();

    clear_pulse();
    chk("clear idle sbox_ready", 256'(sbox_ready_5), 256'(0));
    chk("clear idle s_ready", 256'(s_ready_5), 256'(0));
    load_sbox(1);
    for (int i = 0; i < 5; i++) write_key(i, rnd());
    d = {rnd(), rnd()};
    send(d, 1'b0);
    expect_out("zero sbox", d, 0);
    handshake();

    clear_pulse();
    load_sbox(2);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 16; j++) kv[127 - 8*j -: 8] = 8'(16*i + j);
      write_key(i, kv);
    end
    p = {128'h11223344556677889900AABBCCDDEEFF, 128'h00112233445566778899AABBCCDDEEFF};
    c = cipher(p, 1'b0, 5, 3);
    send(p, 1'b0);
    expect_out("rev enc", c, 0);
    s_valid = 1'b1;
    s_data  = c;
    s_mode  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("hold m_data", m_data_5, c);
      chk("hold m_valid", 256'(m_valid_5), 256'(1));
      chk("hold s_ready", 256'(s_ready_5), 256'(0));
      chk("hold busy", 256'(busy_5), 256'(1));
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("s_ready after hold", 256'(s_ready_5), 256'(1));
    tick();
    s_valid = 1'b0;
`ifdef FEISTEL_DECRYPT_EN
    exp = p;
`else
    exp = cipher(c, 1'b1, 5, 3);
`endif
    expect_out("rev dec", exp, 0);
    handshake();

    clear_pulse();
    load_sbox(3);
    for (int i = 0; i < 5; i++) write_key(i, rnd());
    write_key(6, rnd());
    sbox_wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sbox_wr_data = 8'($urandom);
      tick();
    end
    sbox_wr_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d   = {rnd(), rnd()};
      md  = 1'($urandom);
      exp = cipher(d, md, 5, 3);
      send(d, md);
      expect_out("random", exp, 0);
      handshake();
    end
    chk("s_ready before key fwd", 256'(s_ready_5), 256'(1));
    kv          = rnd();
    d           = {rnd(), rnd()};
    key_wr_en   = 1'b1;
    key_wr_idx  = 3'd0;
    key_wr_data = kv;
    s_valid     = 1'b1;
    s_data      = d;
    s_mode      = 1'b0;
    ks[0]       = kv;
    exp         = cipher(d, 1'b0, 5, 3);
    tick();
    key_wr_en = 1'b0;
    s_valid   = 1'b0;
    expect_out("key fwd", exp, 0);
    handshake();

    d   = {rnd(), rnd()};
    exp = cipher(d, 1'b0, 5, 3);
    send(d, 1'b0);
    tick();
    tick();
    clear_pulse();
    expect_out("clear in run", exp, 3);
    handshake();
    chk("post clear sbox_ready", 256'(sbox_ready_5), 256'(0));
    chk("post clear s_ready", 256'(s_ready_5), 256'(0));
    load_sbox(2);
    chk("reload sbox_ready", 256'(sbox_ready_5), 256'(1));

    send({rnd(), rnd()}, 1'b0);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("abort m_valid", 256'(m_valid_5), 256'(0));
    chk("abort sbox_ready", 256'(sbox_ready_5), 256'(0));
    chk("abort s_ready", 256'(s_ready_5), 256'(0));
    chk("abort busy", 256'(busy_5), 256'(0));
    tick();
    reset_n = 1'b1;
    foreach (ks[i]) ks[i] = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("no output after abort", 256'(m_valid_5), 256'(0));
    end
    load_sbox(3);
    d   = {rnd(), rnd()};
    exp = cipher(d, 1'b0, 5, 3);
    send(d, 1'b0);
    expect_out("keys cleared", exp, 0);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
